// File: rtl/mesh_phase_sequencer.sv
// mesh_phase_sequencer: central schedule generator for the PE mesh.
// Produces the phase / round / step / iteration schedule that every PE
// follows. Each iteration is COMPUTE, then a PUSH_ADDR round, then a
// GET_DATA round. Each round is SORT, then ROW_ALIGN, then COL_ALIGN.
// During SORT, `step` is used as the instruction-ROM address.
module mesh_phase_sequencer #(
  parameter int SQRT_N         = 32,
  parameter int SORT_CYCLES    = 222,
  parameter int COMPUTE_CYCLES = 3,
  parameter int ADDR_WIDTH     = 10,
  parameter int ITER_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ITER_WIDTH-1:0] num_iters,
  input  logic                  stall,
  output logic [2:0]            phase,
  output logic [1:0]            round,
  output logic [ADDR_WIDTH-1:0] step,
  output logic                  phase_last,
  output logic [ITER_WIDTH-1:0] iter,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPUTE,
    S_SORT,
    S_ROW_ALIGN,
    S_COL_ALIGN
  } state_t;

  localparam logic [2:0] PH_SORT = 3'b000;
  localparam logic [2:0] PH_ROW  = 3'b001;
  localparam logic [2:0] PH_COL  = 3'b010;
  localparam logic [2:0] PH_NOP  = 3'b111;

  localparam logic [1:0] RD_PUSH    = 2'b00;
  localparam logic [1:0] RD_GET     = 2'b01;
  localparam logic [1:0] RD_COMPUTE = 2'b10;
  localparam logic [1:0] RD_IDLE    = 2'b11;

  // Final step index of each phase kind.
  localparam logic [ADDR_WIDTH-1:0] COMPUTE_LAST = ADDR_WIDTH'(COMPUTE_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] SORT_LAST    = ADDR_WIDTH'(SORT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_LAST   = ADDR_WIDTH'(SQRT_N - 1);

  state_t                  state_reg;
  logic                    get_round_reg;  // 0: PUSH_ADDR round, 1: GET_DATA round
  logic [ITER_WIDTH-1:0]   num_iters_reg;
  logic [ADDR_WIDTH-1:0]   step_last;

  // Final step index of the phase currently being executed.
  always_comb begin
    step_last = '0;
    case (state_reg)
      S_COMPUTE:   step_last = COMPUTE_LAST;
      S_SORT:      step_last = SORT_LAST;
      S_ROW_ALIGN: step_last = ALIGN_LAST;
      S_COL_ALIGN: step_last = ALIGN_LAST;
      default:     step_last = '0;
    endcase
  end

  // Phase FSM with registered schedule outputs; stall freezes everything except done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      get_round_reg <= 1'b0;
      num_iters_reg <= '0;
      phase         <= PH_NOP;
      round         <= RD_IDLE;
      step          <= '0;
      phase_last    <= 1'b0;
      iter          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          // Start is honoured even under stall; the run then waits at COMPUTE step 0.
          if (start) begin
            num_iters_reg <= num_iters;
            iter          <= '0;
            if (num_iters != '0) begin
              state_reg     <= S_COMPUTE;
              get_round_reg <= 1'b0;
              phase         <= PH_NOP;
              round         <= RD_COMPUTE;
              step          <= '0;
              phase_last    <= (COMPUTE_LAST == '0);
              busy          <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        default: begin
          if (!stall) begin
            if (step != step_last) begin
              step       <= step + ADDR_WIDTH'(1);
              phase_last <= ((step + ADDR_WIDTH'(1)) == step_last);
            end else begin
              step <= '0;
              case (state_reg)
                S_COMPUTE: begin
                  state_reg  <= S_SORT;
                  phase      <= PH_SORT;
                  round      <= RD_PUSH;
                  phase_last <= (SORT_LAST == '0);
                end
                S_SORT: begin
                  state_reg  <= S_ROW_ALIGN;
                  phase      <= PH_ROW;
                  phase_last <= (ALIGN_LAST == '0);
                end
                S_ROW_ALIGN: begin
                  state_reg  <= S_COL_ALIGN;
                  phase      <= PH_COL;
                  phase_last <= (ALIGN_LAST == '0);
                end
                S_COL_ALIGN: begin
                  if (!get_round_reg) begin
                    // PUSH_ADDR round finished: start the GET_DATA round.
                    get_round_reg <= 1'b1;
                    state_reg     <= S_SORT;
                    phase         <= PH_SORT;
                    round         <= RD_GET;
                    phase_last    <= (SORT_LAST == '0);
                  end else if (iter == (num_iters_reg - ITER_WIDTH'(1))) begin
                    // Last iteration complete: return to idle and pulse done.
                    state_reg     <= S_IDLE;
                    get_round_reg <= 1'b0;
                    phase         <= PH_NOP;
                    round         <= RD_IDLE;
                    phase_last    <= 1'b0;
                    iter          <= '0;
                    busy          <= 1'b0;
                    done          <= 1'b1;
                  end else begin
                    get_round_reg <= 1'b0;
                    state_reg     <= S_COMPUTE;
                    phase         <= PH_NOP;
                    round         <= RD_COMPUTE;
                    phase_last    <= (COMPUTE_LAST == '0);
                    iter          <= iter + ITER_WIDTH'(1);
                  end
                end
                default: begin
                  state_reg <= S_IDLE;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mesh_phase_sequencer.sv
// Directed testbench for mesh_phase_sequencer. A small instance
// (SQRT_N=4, SORT_CYCLES=6, COMPUTE_CYCLES=3) carries most scenarios;
// a default-parameter instance covers the full-size iteration length.
module tb_mesh_phase_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Small instance signals
  logic       start = 1'b0;
  logic [7:0] num_iters = 8'd0;
  logic       stall = 1'b0;
  logic [2:0] phase;
  logic [1:0] round;
  logic [9:0] step;
  logic       phase_last;
  logic [7:0] iter;
  logic       busy;
  logic       done;

  // Default instance signals
  logic       start_d = 1'b0;
  logic [7:0] num_iters_d = 8'd0;
  logic       stall_d = 1'b0;
  logic [2:0] phase_d;
  logic [1:0] round_d;
  logic [9:0] step_d;
  logic       phase_last_d;
  logic [7:0] iter_d;
  logic       busy_d;
  logic       done_d;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [25:0] RESET_VEC = {3'b111, 2'b11, 10'd0, 1'b0, 8'd0, 1'b0, 1'b0};

  wire [25:0] obs   = {phase, round, step, phase_last, iter, busy, done};
  wire [25:0] obs_d = {phase_d, round_d, step_d, phase_last_d, iter_d, busy_d, done_d};

  mesh_phase_sequencer #(
    .SQRT_N(4), .SORT_CYCLES(6), .COMPUTE_CYCLES(3), .ADDR_WIDTH(10), .ITER_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_iters(num_iters), .stall(stall),
    .phase(phase), .round(round), .step(step), .phase_last(phase_last),
    .iter(iter), .busy(busy), .done(done)
  );

  mesh_phase_sequencer dut_def (
    .clk(clk), .rst(rst), .start(start_d), .num_iters(num_iters_d), .stall(stall_d),
    .phase(phase_d), .round(round_d), .step(step_d), .phase_last(phase_last_d),
    .iter(iter_d), .busy(busy_d), .done(done_d)
  );

  always #5 clk = ~clk;

  // Expected small-instance outputs k cycles after start acceptance, for an
  // n-iteration run of 31 cycles per iteration (3 + 2*(6 + 4 + 4)).
  function automatic logic [25:0] exp_small(input int k, input int n);
    int it, r, sub, st, len;
    logic [2:0] ph;
    logic [1:0] rd;
    if (k >= 31 * n)
      return {3'b111, 2'b11, 10'd0, 1'b0, 8'd0, 1'b0, (k == 31 * n)};
    it = k / 31;
    r  = k % 31;
    if (r < 3) begin
      ph = 3'b111; rd = 2'b10; st = r; len = 3;
    end else begin
      if (r < 17) begin rd = 2'b00; sub = r - 3; end
      else        begin rd = 2'b01; sub = r - 17; end
      if (sub < 6)       begin ph = 3'b000; st = sub;      len = 6; end
      else if (sub < 10) begin ph = 3'b001; st = sub - 6;  len = 4; end
      else               begin ph = 3'b010; st = sub - 10; len = 4; end
    end
    return {ph, rd, 10'(st), (st == len - 1), 8'(it), 1'b1, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if (obs !== RESET_VEC) begin
      $display("FAIL reset_small got %h want %h", obs, RESET_VEC);
      n_err++;
    end
    n_vec++;
    if (obs_d !== RESET_VEC) begin
      $display("FAIL reset_default got %h want %h", obs_d, RESET_VEC);
      n_err++;
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    logic [25:0] e;
    num_iters = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 63; k++) begin
      e = exp_small(k, 2);
      n_vec++;
      if (obs !== e) begin
        $display("FAIL nominal k=%0d got %h want %h", k, obs, e);
        n_err++;
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [25:0] e;
    int eff;
    int waited;
    num_iters = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= 37; c++) begin
      eff = (c <= 10) ? ((c < 5) ? c : 5) : c - 5;
      e = exp_small(eff, 1);
      n_vec++;
      if (obs !== e) begin
        $display("FAIL stall c=%0d got %h want %h", c, obs, e);
        n_err++;
      end
      stall = (c >= 5 && c < 10);
      tick();
    end
    // Start coinciding with stall in idle is accepted and held at COMPUTE step 0.
    stall = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_vec++;
      if (obs !== exp_small(0, 1)) begin
        $display("FAIL stall_start hold=%0d got %h want %h", c, obs, exp_small(0, 1));
        n_err++;
      end
      tick();
    end
    stall = 1'b0;
    tick();
    n_vec++;
    if (obs !== exp_small(1, 1)) begin
      $display("FAIL stall_start_resume got %h want %h", obs, exp_small(1, 1));
      n_err++;
    end
    waited = 0;
    while (!done && waited < 100) begin
      tick();
      waited++;
    end
    n_vec++;
    if (waited != 30) begin
      $display("FAIL stall_start_len got %0d want %0d", waited, 30);
      n_err++;
    end
    tick();
  endtask

  task automatic test_zero_iters();
    num_iters = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++;
    if ({phase, round, busy, done} !== {3'b111, 2'b11, 1'b0, 1'b1}) begin
      $display("FAIL zero_iters_pulse got %b want %b", {phase, round, busy, done}, 7'b1111101);
      n_err++;
    end
    tick();
    n_vec++;
    if (obs !== RESET_VEC) begin
      $display("FAIL zero_iters_after got %h want %h", obs, RESET_VEC);
      n_err++;
    end
  endtask

  task automatic test_ignored_start_and_reset();
    logic [25:0] e;
    int dones;
    num_iters = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 63; k++) begin
      e = exp_small(k, 2);
      n_vec++;
      if (obs !== e) begin
        $display("FAIL ignored_start k=%0d got %h want %h", k, obs, e);
        n_err++;
      end
      if (k == 24) begin
        start = 1'b1;
        num_iters = 8'd3;
      end else begin
        start = 1'b0;
        num_iters = 8'd2;
      end
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      e = exp_small(k, 2);
      n_vec++;
      if (obs !== e) begin
        $display("FAIL pre_reset k=%0d got %h want %h", k, obs, e);
        n_err++;
      end
      if (k < 14) tick();
    end
    rst = 1'b1;
    tick();
    n_vec++;
    if (obs !== RESET_VEC) begin
      $display("FAIL midrun_reset got %h want %h", obs, RESET_VEC);
      n_err++;
    end
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 70; c++) begin
      if (done || busy) dones++;
      tick();
    end
    n_vec++;
    if (dones != 0) begin
      $display("FAIL post_reset_activity got %0d want %0d", dones, 0);
      n_err++;
    end
  endtask

  task automatic test_defaults();
    int cnt;
    int max_step;
    num_iters_d = 8'd1;
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    cnt = 0;
    max_step = 0;
    while (busy_d && cnt < 2000) begin
      cnt++;
      if (phase_d == 3'b000 && int'(step_d) > max_step) max_step = int'(step_d);
      tick();
    end
    n_vec++;
    if (cnt != 575) begin
      $display("FAIL default_busy_len got %0d want %0d", cnt, 575);
      n_err++;
    end
    n_vec++;
    if (max_step != 221) begin
      $display("FAIL default_sort_max_step got %0d want %0d", max_step, 221);
      n_err++;
    end
    n_vec++;
    if (done_d !== 1'b1) begin
      $display("FAIL default_done got %b want %b", done_d, 1'b1);
      n_err++;
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_zero_iters();
    test_ignored_start_and_reset();
    test_defaults();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
